// File: rtl/bus_line_fill_pkg.sv
// Shared types and constants for the bus_line_fill cache-line fill engine.
// Package name: bus_fill_pkg.
package bus_fill_pkg;

  // Fill engine FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  // Default geometry: 8 beats of 64 bits give a 64-byte line.
  localparam int DEF_BUS_DATA_WIDTH = 64;
  localparam int DEF_LINE_BEATS     = 8;
  localparam int LINE_BYTES         = DEF_LINE_BEATS * DEF_BUS_DATA_WIDTH / 8;
  localparam int OFFSET_BITS        = $clog2(DEF_LINE_BEATS);

  // Memory read: read bit set, memory type 4'b0001, all other fields zero.
  localparam logic [12:0] READ_TAG_DEF = 13'h1100;

  // Clear the in-line byte offset of an address.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int          line_bytes);
    return addr & ~(64'(line_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/bus_line_fill_if.sv
// Sysbus master-port signal bundle used by the line fill engine.
// master: the fill engine; slave: the bus / memory side.
interface bus_line_fill_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) ();

  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (
    output bus_reqcyc,
    output bus_req,
    output bus_reqtag,
    input  bus_reqack,
    input  bus_respcyc,
    input  bus_resp,
    input  bus_resptag,
    output bus_respack
  );

  modport slave (
    input  bus_reqcyc,
    input  bus_req,
    input  bus_reqtag,
    output bus_reqack,
    output bus_respcyc,
    output bus_resp,
    output bus_resptag,
    input  bus_respack
  );

endinterface

// File: rtl/bus_line_fill_line_buffer.sv
// Line buffer: LINE_BEATS x BUS_DATA_WIDTH register file, one indexed write
// port and a flat read-out where beat i sits at [i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH].
module line_buffer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LINE_BEATS     = 8,
  parameter int IDX_W          = $clog2(LINE_BEATS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 we,
  input  logic [IDX_W-1:0]                     widx,
  input  logic [BUS_DATA_WIDTH-1:0]            wdata,
  output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] rdata
);

  logic [LINE_BEATS-1:0][BUS_DATA_WIDTH-1:0] mem_q;
  logic [LINE_BEATS-1:0][BUS_DATA_WIDTH-1:0] mem_d;

  // Next-state: overwrite only the addressed beat on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[widx] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage flops, cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q;

endmodule

// File: rtl/bus_line_fill.sv
// bus_line_fill: cache-line fill engine. Accepts one fill request, issues a
// single read on the Sysbus, collects LINE_BEATS response beats into the line
// buffer and hands the whole line to the cache with a valid/ready handshake.
// Optional feature macro: FILL_CRIT_WORD_EN (critical-word early strobe).
module bus_line_fill
  import bus_fill_pkg::*;
#(
  parameter int                     BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
  parameter int                     BUS_TAG_WIDTH  = 13,
  parameter int                     LINE_BEATS     = DEF_LINE_BEATS,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG     = BUS_TAG_WIDTH'(READ_TAG_DEF)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  // fill request from the caches
  input  logic                                 fill_valid,
  output logic                                 fill_ready,
  input  logic [63:0]                          fill_addr,
  // completed line to the caches
  output logic                                 line_valid,
  input  logic                                 line_ready,
  output logic [63:0]                          line_addr,
  output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] line_data,
  // Sysbus master port
  bus_line_fill_if.master                      bus,
  // critical word
  output logic                                 crit_valid,
  output logic [BUS_DATA_WIDTH-1:0]            crit_data
);

  localparam int IDX_W      = $clog2(LINE_BEATS);
  localparam int BEAT_SHIFT = $clog2(BUS_DATA_WIDTH / 8);
  localparam int LINE_SIZE  = LINE_BEATS * BUS_DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_BEATS - 1);

  fill_state_t               state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic [63:0]               line_addr_q, line_addr_d;
  logic                      fill_ready_q, fill_ready_d;
  logic                      line_valid_q, line_valid_d;
  logic                      reqcyc_q, reqcyc_d;
  logic [BUS_DATA_WIDTH-1:0] req_q, req_d;
  logic [BUS_TAG_WIDTH-1:0]  reqtag_q, reqtag_d;
  logic                      beat_s;

  // A beat is consumed only while collecting the response.
  assign beat_s = (state_q == RESP) && bus.bus_respcyc;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_addr_d = line_addr_q;
    case (state_q)
      IDLE: begin
        if (fill_valid) begin
          state_d     = REQ;
          line_addr_d = line_align(fill_addr, LINE_SIZE);
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.bus_reqack) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (bus.bus_respcyc) begin
          // counter wraps to 0 naturally after the last beat
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = RESP;
        end
      end
      DONE: begin
        if (line_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    fill_ready_d = (state_d == IDLE);
    line_valid_d = (state_d == DONE);
    reqcyc_d     = (state_d == REQ);
    if (state_d == REQ) begin
      req_d    = BUS_DATA_WIDTH'(line_addr_d);
      reqtag_d = READ_TAG;
    end else begin
      req_d    = '0;
      reqtag_d = '0;
    end
  end

  // FSM state, beat counter, latched address and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_addr_q  <= '0;
      fill_ready_q <= 1'b1;
      line_valid_q <= 1'b0;
      reqcyc_q     <= 1'b0;
      req_q        <= '0;
      reqtag_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_addr_q  <= line_addr_d;
      fill_ready_q <= fill_ready_d;
      line_valid_q <= line_valid_d;
      reqcyc_q     <= reqcyc_d;
      req_q        <= req_d;
      reqtag_q     <= reqtag_d;
    end
  end

  line_buffer #(
    .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
    .LINE_BEATS     (LINE_BEATS),
    .IDX_W          (IDX_W)
  ) u_line_buffer (
    .clk   (clk),
    .reset (reset),
    .we    (beat_s),
    .widx  (cnt_q),
    .wdata (bus.bus_resp),
    .rdata (line_data)
  );

  assign fill_ready      = fill_ready_q;
  assign line_valid      = line_valid_q;
  assign line_addr       = line_addr_q;
  assign bus.bus_reqcyc  = reqcyc_q;
  assign bus.bus_req     = req_q;
  assign bus.bus_reqtag  = reqtag_q;
  // response tag is not inspected: only one request is ever outstanding
  assign bus.bus_respack = beat_s;

`ifdef FILL_CRIT_WORD_EN
  logic [IDX_W-1:0] offset_q, offset_d;

  // Capture the beat index of the requested word when a fill is accepted.
  always_comb begin
    if ((state_q == IDLE) && fill_valid) begin
      offset_d = fill_addr[BEAT_SHIFT +: IDX_W];
    end else begin
      offset_d = offset_q;
    end
  end

  // Critical-word offset register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_d;
    end
  end

  assign crit_valid = beat_s && (cnt_q == offset_q);
  assign crit_data  = crit_valid ? bus.bus_resp : '0;
`else
  assign crit_valid = 1'b0;
  assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_bus_line_fill.sv
// Self-checking bench for bus_line_fill: a small bus model drives beats and
// pushes them into a scoreboard queue; completed lines are popped and compared.
module tb_bus_line_fill;
  localparam int W  = 64;
  localparam int TW = 13;
  localparam int B  = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             fill_valid = 1'b0;
  logic             fill_ready;
  logic [63:0]      fill_addr = 64'd0;
  logic             line_valid;
  logic             line_ready = 1'b0;
  logic [63:0]      line_addr;
  logic [W*B-1:0]   line_data;
  logic             crit_valid;
  logic [W-1:0]     crit_data;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] last_line [B];

  always #5 clk = ~clk;

  bus_line_fill_if #(.BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(TW)) bif ();

  bus_line_fill dut (
    .clk        (clk),
    .reset      (reset),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_addr  (fill_addr),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_addr  (line_addr),
    .line_data  (line_data),
    .bus        (bif.master),
    .crit_valid (crit_valid),
    .crit_data  (crit_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Issue a fill and play the request phase; ends on a negedge with DUT in RESP.
  task automatic start_fill(input logic [63:0] addr, input int ack_delay, input bit stray);
    fill_valid = 1'b1;
    fill_addr  = addr;
    #1;
    check_eq("fill_ready_idle", {63'd0, fill_ready}, 64'd1);
    @(negedge clk);
    fill_valid = 1'b0;
    for (int i = 0; i <= ack_delay; i++) begin
      if (i > 0) @(negedge clk);
      if (stray) begin
        bif.bus_respcyc = 1'b1;
        bif.bus_resp    = 64'hDEAD_0000 + 64'(i);
      end
      #1;
      check_eq("reqcyc_req", {63'd0, bif.bus_reqcyc}, 64'd1);
      check_eq("bus_req", bif.bus_req, addr & ~64'h3F);
      check_eq("reqtag", {51'd0, bif.bus_reqtag}, 64'h1100);
      check_eq("fill_ready_req", {63'd0, fill_ready}, 64'd0);
      check_eq("respack_req", {63'd0, bif.bus_respack}, 64'd0);
      bif.bus_respcyc = 1'b0;
      bif.bus_reqack  = (i == ack_delay);
    end
    @(negedge clk);
    bif.bus_reqack = 1'b0;
    #1;
    check_eq("reqcyc_resp", {63'd0, bif.bus_reqcyc}, 64'd0);
  endtask

  // Drive n accepted beats (optionally gapped) and push them to the scoreboard.
  task automatic send_beats(input logic [63:0] base, input bit gapped, input int offset, input int n);
    int k;
    int cyc;
    logic [W-1:0] v;
    logic exp_cv;
    logic [W-1:0] exp_cd;
    k = 0;
    cyc = 0;
    while (k < n) begin
      if (gapped && (cyc % 2 == 1)) begin
        bif.bus_respcyc = 1'b0;
        bif.bus_resp    = 64'hBAD0_BAD0;
        #1;
        check_eq("respack_gap", {63'd0, bif.bus_respack}, 64'd0);
        check_eq("crit_valid_gap", {63'd0, crit_valid}, 64'd0);
      end else begin
        v = base + 64'(k);
        bif.bus_respcyc = 1'b1;
        bif.bus_resp    = v;
        sb_q.push_back(v);
`ifdef FILL_CRIT_WORD_EN
        exp_cv = (k == offset);
        exp_cd = exp_cv ? v : 64'd0;
`else
        exp_cv = 1'b0;
        exp_cd = 64'd0;
`endif
        #1;
        check_eq("respack_beat", {63'd0, bif.bus_respack}, 64'd1);
        check_eq("crit_valid", {63'd0, crit_valid}, {63'd0, exp_cv});
        check_eq("crit_data", crit_data, exp_cd);
        k++;
      end
      check_eq("line_valid_resp", {63'd0, line_valid}, 64'd0);
      @(negedge clk);
      cyc++;
    end
    bif.bus_respcyc = 1'b0;
  endtask

  // Completed line: pop the scoreboard and compare every beat.
  task automatic check_line(input logic [63:0] addr);
    logic [W-1:0] e;
    #1;
    check_eq("line_valid_done", {63'd0, line_valid}, 64'd1);
    check_eq("line_addr", line_addr, addr & ~64'h3F);
    for (int i = 0; i < B; i++) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 64'd0, 64'd1);
        e = '0;
      end else begin
        e = sb_q.pop_front();
      end
      check_eq($sformatf("line_beat%0d", i), line_data[i*W +: W], e);
      last_line[i] = e;
    end
  endtask

  // Hold the line for `hold` cycles (optionally with a pending fill), then take it.
  task automatic take_line(input int hold, input bit next_v, input logic [63:0] next_addr);
    for (int i = 0; i < hold; i++) begin
      line_ready = 1'b0;
      if (next_v) begin
        fill_valid = 1'b1;
        fill_addr  = next_addr;
      end
      #1;
      check_eq("bp_line_valid", {63'd0, line_valid}, 64'd1);
      check_eq("bp_fill_ready", {63'd0, fill_ready}, 64'd0);
      check_eq("bp_reqcyc", {63'd0, bif.bus_reqcyc}, 64'd0);
      for (int j = 0; j < B; j++) check_eq("bp_stable", line_data[j*W +: W], last_line[j]);
      @(negedge clk);
    end
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;
    #1;
    check_eq("idle_line_valid", {63'd0, line_valid}, 64'd0);
    check_eq("idle_fill_ready", {63'd0, fill_ready}, 64'd1);
  endtask

  initial begin
    bif.bus_reqack  = 1'b0;
    bif.bus_respcyc = 1'b0;
    bif.bus_resp    = '0;
    bif.bus_resptag = 13'h1100;
    #12;
    check_eq("rst_fill_ready", {63'd0, fill_ready}, 64'd1);
    check_eq("rst_line_valid", {63'd0, line_valid}, 64'd0);
    check_eq("rst_reqcyc", {63'd0, bif.bus_reqcyc}, 64'd0);
    check_eq("rst_line_addr", line_addr, 64'd0);
    check_eq("rst_line_beat0", line_data[W-1:0], 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // basic fill, reqack after 2 cycles, contiguous beats
    start_fill(64'h1028, 2, 1'b0);
    send_beats(64'hA0, 1'b0, 5, B);
    check_line(64'h1028);
    take_line(0, 1'b0, 64'd0);

    // stray response in IDLE leaves the buffer untouched
    bif.bus_respcyc = 1'b1;
    bif.bus_resp    = 64'hFFFF_EEEE;
    #1;
    check_eq("stray_idle_respack", {63'd0, bif.bus_respack}, 64'd0);
    @(negedge clk);
    bif.bus_respcyc = 1'b0;
    #1;
    for (int j = 0; j < B; j++) check_eq("stray_idle_buf", line_data[j*W +: W], last_line[j]);

    // stray response during REQ, then gapped beats
    start_fill(64'h4040, 1, 1'b1);
    send_beats(64'hB0, 1'b1, 0, B);
    check_line(64'h4040);
    // back-pressure with a pending second request
    take_line(10, 1'b1, 64'h2038);

    // second request: critical word is beat 7
    start_fill(64'h2038, 0, 1'b0);
    send_beats(64'hD0, 1'b0, 7, B);
    check_line(64'h2038);
    take_line(0, 1'b0, 64'd0);

    // reset after 3 beats
    start_fill(64'h3010, 0, 1'b0);
    send_beats(64'hC0, 1'b0, 2, 3);
    bif.bus_respcyc = 1'b1;
    bif.bus_resp    = 64'hC3;
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_fill_ready", {63'd0, fill_ready}, 64'd1);
    check_eq("mid_rst_line_valid", {63'd0, line_valid}, 64'd0);
    check_eq("mid_rst_reqcyc", {63'd0, bif.bus_reqcyc}, 64'd0);
    check_eq("mid_rst_req", bif.bus_req, 64'd0);
    check_eq("mid_rst_respack", {63'd0, bif.bus_respack}, 64'd0);
    check_eq("mid_rst_crit", {63'd0, crit_valid}, 64'd0);
    check_eq("mid_rst_line_addr", line_addr, 64'd0);
    for (int j = 0; j < B; j++) check_eq("mid_rst_buf", line_data[j*W +: W], 64'd0);
    sb_q.delete();
    bif.bus_respcyc = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // clean fill after the reset
    start_fill(64'h5000, 1, 1'b0);
    send_beats(64'hE0, 1'b1, 0, B);
    check_line(64'h5000);
    take_line(0, 1'b0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_line_fill.md
Name: bus_line_fill

Overview:
- Cache-line fill engine between the Core's instruction/data caches and the Sysbus master port (bus_reqcyc/bus_req/bus_reqtag out, bus_resp* in).
- Accepts one line-fill request at a time and issues a single read request on the bus.
- Collects LINE_BEATS response beats into a line buffer and presents the full line to the requesting cache with a valid/ready handshake.

Parameters:
- BUS_DATA_WIDTH, 64, width of one bus beat and of bus_req.
- BUS_TAG_WIDTH, 13, width of request/response tags.
- LINE_BEATS, 8, beats per cache line (64-byte line at 64-bit beats); must be a power of 2.
- READ_TAG, 13'h1100, tag driven on bus_reqtag for a memory read (read bit = 1, memory type = 4'b0001, rest 0).

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high reset.
- fill_valid, in, 1, fill request strobe.
- fill_ready, out, 1, engine can accept a request (high only in IDLE).
- fill_addr, in, 64, byte address of requested data; need not be line-aligned.
- line_valid, out, 1, line buffer holds a complete line.
- line_ready, in, 1, consumer takes the line.
- line_addr, out, 64, line-aligned address of the buffered line.
- line_data, out, BUS_DATA_WIDTH*LINE_BEATS, beat i occupies bits [i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH].
- bus_reqcyc, out, 1, request valid.
- bus_req, out, BUS_DATA_WIDTH, request address.
- bus_reqtag, out, BUS_TAG_WIDTH, request tag.
- bus_reqack, in, 1, request accepted.
- bus_respcyc, in, 1, response beat valid.
- bus_resp, in, BUS_DATA_WIDTH, response data.
- bus_resptag, in, BUS_TAG_WIDTH, response tag.
- bus_respack, out, 1, response beat consumed.
- crit_valid, out, 1, critical-word strobe (see Optional Feature).
- crit_data, out, BUS_DATA_WIDTH, critical word.

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. Reset state is IDLE.
- Reset values:
  - all outputs 0 except fill_ready = 1;
  - beat counter = 0;
  - line buffer and line_addr = 0.
- IDLE:
  - fill_ready = 1.
  - On fill_valid, latch line_addr = fill_addr with low log2(LINE_BEATS*BUS_DATA_WIDTH/8) bits cleared; latch beat offset = fill_addr[5:3] for the default sizes.
  - Go to REQ.
- REQ:
  - bus_reqcyc = 1, bus_req = line_addr, bus_reqtag = READ_TAG.
  - All three are held stable until the cycle bus_reqack = 1, then go to RESP with beat counter = 0.
  - Minimum request-to-RESP latency is 1 cycle after entering REQ.
- RESP:
  - bus_respack = bus_respcyc, combinational, only in RESP.
  - Each cycle with bus_respcyc = 1 writes bus_resp into beat[counter] and increments the counter.
  - bus_resptag is not checked; a single outstanding request makes the stream unambiguous.
  - Beats are contiguous or gapped; gaps (respcyc = 0) stall the counter.
  - On the beat where counter == LINE_BEATS-1, go to DONE; the counter wraps to 0.
- DONE:
  - line_valid = 1; line_data and line_addr are held stable.
  - When line_ready = 1, return to IDLE next cycle.
  - fill_ready stays 0 in DONE, so there is no same-cycle handoff/new-request overlap.
- bus_respcyc outside RESP: bus_respack stays 0 and data is ignored.
- fill_valid outside IDLE: ignored; the requester must hold it until it sees fill_ready.
- Reset at any point returns to IDLE immediately (async). A fill in flight is abandoned; the upstream bus is assumed reset alongside.

Optional Feature:
- Macro: FILL_CRIT_WORD_EN.
- Defined:
  - In RESP, on the beat where counter == latched offset, crit_valid pulses high for exactly that cycle.
  - crit_data = bus_resp in that same cycle, combinational.
  - Lets the cache wake the pipeline before the line completes.
- Undefined: crit_valid and crit_data are tied to 0 and the offset register is removed.

Decomposition:
- Package bus_fill_pkg:
  - FSM state enum fill_state_t;
  - LINE_BYTES and OFFSET_BITS localparams;
  - default READ_TAG constant.
- One natural sub-module, line_buffer: LINE_BEATS x BUS_DATA_WIDTH register file with write-enable/index input and a flat read-out.
- FSM and bus handshake stay in bus_line_fill.

Test Plan:
- Basic fill: fill_addr = 64'h1028, reqack after 2 cycles, 8 back-to-back beats 64'hA0..A7.
  - bus_req = 64'h1000 held 3 cycles.
  - line_valid rises the cycle after the 8th beat; line_data beat i = 64'hA0+i; line_addr = 64'h1000.
- Gapped response: beats arrive with respcyc low every other cycle.
  - bus_respack mirrors respcyc only in RESP.
  - Same line content; DONE reached after 8 accepted beats, not after 8 cycles.
- Back-pressure: hold line_ready = 0 for 10 cycles in DONE while driving fill_valid.
  - line_data stable; fill_ready = 0; no new bus_reqcyc.
  - After line_ready the FSM goes to IDLE and the second request is accepted.
- Stray response: drive bus_respcyc in IDLE and REQ.
  - bus_respack = 0; buffer unchanged.
- Reset mid-fill: assert reset after 3 beats.
  - All outputs at reset values asynchronously; fill_ready = 1.
  - The next fill produces a correct 8-beat line.
- FILL_CRIT_WORD_EN: fill_addr = 64'h2038.
  - crit_valid high exactly on beat 7; crit_data = beat 7 value.
  - With the macro undefined, crit_valid stays 0.
